// File: rtl/ldpc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldpc_pkg : shared defaults, widths and FSM encoding for the       |
// |            LDPC codeword packer.                 Revision: 1.0    |
// +------------------------------------------------------------------+
package ldpc_pkg;

  localparam int DEF_MAX_BLOCK_SIZE = 64;
  localparam int DEF_MAX_COLS       = 24;
  localparam int DEF_IN_WIDTH       = 32;

  localparam int WIDTH_BLOCK_SZ = $clog2(DEF_MAX_BLOCK_SIZE + 1);
  localparam int WIDTH_COLS     = $clog2(DEF_MAX_COLS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    START = 3'd3,
    GAP   = 3'd4,
    BURST = 3'd5
  } packer_state_t;

endpackage
`default_nettype wire

// File: rtl/ldpc_codeword_packer_bit_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldpc_bit_accumulator : gathers stream words and emits one Z-bit   |
// |                        block whenever enough bits are held.       |
// |                                                 Revision: 1.0     |
// +------------------------------------------------------------------+
module ldpc_bit_accumulator
  import ldpc_pkg::*;
#(
  parameter int MAX_BLOCK_SIZE = DEF_MAX_BLOCK_SIZE,
  parameter int IN_WIDTH       = DEF_IN_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 word_valid,
  input  logic [IN_WIDTH-1:0]                  word_data,
  input  logic [$clog2(MAX_BLOCK_SIZE+1)-1:0]  block_size,
  output logic                                 blk_valid,
  output logic [MAX_BLOCK_SIZE-1:0]            blk_data
);

  localparam int AW = MAX_BLOCK_SIZE + IN_WIDTH;
  localparam int CW = $clog2(AW + 1);

  logic [AW-1:0]             acc_q, acc_d, acc_sum;
  logic [CW-1:0]             cnt_q, cnt_d, cnt_sum, z_ext;
  logic [MAX_BLOCK_SIZE-1:0] z_mask;

  always_comb begin
    z_ext     = CW'(block_size);
    acc_sum   = acc_q | ({{MAX_BLOCK_SIZE{1'b0}}, word_data} << cnt_q);
    cnt_sum   = cnt_q + CW'(IN_WIDTH);
    blk_valid = word_valid && (cnt_sum >= z_ext);
    // Shifting by Z == MAX_BLOCK_SIZE yields zero, so the mask becomes all ones.
    z_mask    = ~({MAX_BLOCK_SIZE{1'b1}} << block_size);
    blk_data  = acc_sum[MAX_BLOCK_SIZE-1:0] & z_mask;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (word_valid) begin
      if (blk_valid) begin
        acc_d = acc_sum >> block_size;
        cnt_d = cnt_sum - z_ext;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ldpc_codeword_packer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldpc_codeword_packer : buffers one codeword frame from a stream   |
// |                        and replays it as a decoder load burst.    |
// |                                                 Revision: 1.0     |
// +------------------------------------------------------------------+
module ldpc_codeword_packer
  import ldpc_pkg::*;
#(
  parameter int MAX_BLOCK_SIZE = DEF_MAX_BLOCK_SIZE,
  parameter int MAX_COLS       = DEF_MAX_COLS,
  parameter int IN_WIDTH       = DEF_IN_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_load,
  input  logic [$clog2(MAX_BLOCK_SIZE+1)-1:0]  cfg_block_size,
  input  logic [$clog2(MAX_COLS+1)-1:0]        cfg_cols,
  output logic                                 cfg_err,
  input  logic [IN_WIDTH-1:0]                  s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 s_last,
  output logic                                 dec_start,
  output logic [MAX_BLOCK_SIZE-1:0]            dec_data,
  output logic                                 dec_valid,
  output logic                                 len_err,
  output logic                                 busy
);

  localparam int WZ = $clog2(MAX_BLOCK_SIZE + 1);
  localparam int WC = $clog2(MAX_COLS + 1);

  localparam logic [WZ-1:0] Z_MIN     = WZ'(IN_WIDTH);
  localparam logic [WZ-1:0] Z_MAX     = WZ'(MAX_BLOCK_SIZE);
  localparam logic [WC-1:0] COLS_MAX  = WC'(MAX_COLS);
  localparam logic [WC-1:0] COLS_LAST = WC'(MAX_COLS - 1);

  packer_state_t state_q, state_d;

  logic [WZ-1:0]             z_q, z_d;
  logic [WC-1:0]             cols_q, cols_d;
  logic [WC-1:0]             col_q, col_d, col_next;
  logic [WC-1:0]             burst_q, burst_d;
  logic                      dec_start_q, dec_start_d;
  logic                      dec_valid_q, dec_valid_d;
  logic [MAX_BLOCK_SIZE-1:0] dec_data_q, dec_data_d;
  logic                      len_err_q, len_err_d;
  logic                      cfg_err_q, cfg_err_d;
  logic                      cfg_bad;

  logic                      acc_clear, acc_word_valid;
  logic                      blk_valid;
  logic [MAX_BLOCK_SIZE-1:0] blk_data;
  logic                      buf_we;
  logic [MAX_BLOCK_SIZE-1:0] col_buf_q [MAX_COLS];
  logic [WC-1:0]             rd_idx;
  logic [WZ-1:0]             shamt;
  logic [MAX_BLOCK_SIZE-1:0] col_word;

  assign s_ready        = (state_q == FILL) || (state_q == DRAIN);
  assign busy           = (state_q != IDLE);
  assign acc_word_valid = (state_q == FILL) && s_valid;
  assign acc_clear      = (state_q == IDLE) && !cfg_load;
  assign buf_we         = acc_word_valid && blk_valid;

  assign dec_start = dec_start_q;
  assign dec_valid = dec_valid_q;
  assign dec_data  = dec_data_q;
  assign len_err   = len_err_q;
  assign cfg_err   = cfg_err_q;

  ldpc_bit_accumulator #(
    .MAX_BLOCK_SIZE (MAX_BLOCK_SIZE),
    .IN_WIDTH       (IN_WIDTH)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (acc_clear),
    .word_valid (acc_word_valid),
    .word_data  (s_data),
    .block_size (z_q),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data)
  );

  // Columns never written (early s_last) read back as zero via the col_q bound.
  always_comb begin
    rd_idx   = (state_q == BURST) ? burst_q + WC'(1) : '0;
    shamt    = Z_MAX - z_q;
    col_word = '0;
    if (rd_idx < col_q) begin
      col_word = col_buf_q[rd_idx] << shamt;
    end
  end

  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    cols_d      = cols_q;
    col_d       = col_q;
    burst_d     = burst_q;
    dec_start_d = 1'b0;
    dec_valid_d = 1'b0;
    dec_data_d  = '0;
    len_err_d   = 1'b0;
    cfg_err_d   = 1'b0;
    col_next    = col_q + WC'(1);
    cfg_bad     = (cfg_block_size < Z_MIN) || (cfg_block_size > Z_MAX) ||
                  (cfg_cols == '0) || (cfg_cols > COLS_MAX);

    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            z_d    = cfg_block_size;
            cols_d = cfg_cols;
          end
        end else begin
          state_d = FILL;
          col_d   = '0;
        end
      end
      FILL: begin
        if (s_valid) begin
          if (blk_valid) begin
            col_d = col_next;
          end
          if (blk_valid && (col_next == cols_q)) begin
            if (s_last) begin
              state_d     = START;
              dec_start_d = 1'b1;
            end else begin
              state_d   = DRAIN;
              len_err_d = 1'b1;
            end
          end else if (s_last) begin
            state_d     = START;
            dec_start_d = 1'b1;
            len_err_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (s_valid && s_last) begin
          state_d     = START;
          dec_start_d = 1'b1;
        end
      end
      START: begin
        state_d = GAP;
      end
      GAP: begin
        state_d     = BURST;
        burst_d     = '0;
        dec_valid_d = 1'b1;
        dec_data_d  = col_word;
      end
      BURST: begin
        if (burst_q == COLS_LAST) begin
          state_d = IDLE;
        end else begin
          burst_d     = burst_q + WC'(1);
          dec_valid_d = 1'b1;
          dec_data_d  = col_word;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      z_q         <= Z_MAX;
      cols_q      <= COLS_MAX;
      col_q       <= '0;
      burst_q     <= '0;
      dec_start_q <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_data_q  <= '0;
      len_err_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      cols_q      <= cols_d;
      col_q       <= col_d;
      burst_q     <= burst_d;
      dec_start_q <= dec_start_d;
      dec_valid_q <= dec_valid_d;
      dec_data_q  <= dec_data_d;
      len_err_q   <= len_err_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      col_buf_q[col_q] <= blk_data;
    end
  end

endmodule
`default_nettype wire
